bcd_serial_adder: RTL
=====================

Name: bcd_serial_adder

Overview:
- Parametrised, sequential successor to the team's 2-digit combinational BCD adder.
- Adds two DIGITS-wide packed-BCD operands one digit per clock, least-significant digit first, using a start/busy/done handshake.
- Registers a (DIGITS+1)-digit result and drives one active-low seven-segment bus per result digit.
- Sits between switch/operand registers and the HEX display bank of board-level tops.

Parameters:
- DIGITS, 4, number of BCD digits per operand (legal range 1..8).

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- a  in  4*DIGITS  packed BCD operand; digit i is a[4i+3:4i].
- b  in  4*DIGITS  packed BCD operand, same packing.
- sub  in  1  subtract select; present only when BCD_SUB_EN is defined.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- sum  out  4*(DIGITS+1)  registered packed-BCD result; top digit is the carry digit.
- err  out  1  high if any captured operand digit was greater than 9.
- neg  out  1  result is negative; used only with BCD_SUB_EN.
- hex  out  7*(DIGITS+1)  active-low segments, 7 bits per sum digit, bit order gfedcba (bit0 = a).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, err=0, neg=0, sum=0; hex shows "0" on every digit (7'b1000000).
- States: IDLE, RUN, DONE, and COMP (COMP exists only with BCD_SUB_EN).
- IDLE/DONE, start=1 (cycle 0):
  - Capture a and b into internal registers.
  - Clear carry, digit index, err and neg.
  - Go to RUN; busy=1 from cycle 1.
- RUN, per cycle, at index i:
  - Compute t = a_i + b_i + c (5-bit).
  - If t>9: digit = t-10, c=1. Otherwise digit = t, c=0.
  - Write the digit to sum digit i and increment i.
- Invalid input digit: if a_i>9 or b_i>9, set err (sticky until the next start), write 4'hF to sum digit i, force c=0.
- After digit DIGITS-1: write c to sum digit DIGITS, enter DONE.
  - done=1 for exactly one cycle, busy=0.
  - Addition latency: done is asserted in cycle DIGITS+1 after start is sampled.
- DONE holds sum, err and neg until the next accepted start. done is 0 after its first cycle.
- start while busy=1 is ignored; captured operands are unaffected.
- Simultaneous done and start: the start sampled in the done cycle is accepted (DONE accepts start).
- sum updates digit by digit during RUN. Consumers use sum only when busy=0.
- Seven-segment decode (combinational from the sum register):
  - Codes 0-9 use the standard active-low patterns, e.g. 0=1000000, 1=1111001, 8=0000000.
  - Codes 10-15 are blank (1111111).
- rst asserted mid-operation: immediate return to the reset values above. The partial result is discarded.

Optional Feature:
- Macro: BCD_SUB_EN.
- Defined, sub=1 at start selects a-b:
  - RUN adds a to the nine's complement of each b digit, with initial carry 1.
  - Final carry 1: result non-negative; top digit 0, neg=0; go to DONE. Latency DIGITS+1.
  - Final carry 0: neg=1; enter COMP.
- COMP:
  - Re-runs DIGITS cycles computing 0 + nine's complement(sum digit) with initial carry 1, overwriting sum with the magnitude.
  - Top digit is 0; then go to DONE. Latency 2*DIGITS+1.
- err handling in subtract mode is identical to add mode, checked on raw a/b digits.
- Undefined: sub port absent, add only, neg tied 0, COMP state not built.

Test Plan (DIGITS=4):
- Reset asserted, then released -> sum=0x00000, busy=0, done=0, err=0, every hex digit=7'b1000000.
- a=0x1234, b=0x8766, start pulse -> busy high cycles 1-4, done=1 in cycle 5, sum=0x10000, hex4=1111001, hex0..hex3=1000000.
- a=0x9999, b=0x9999 -> sum=0x19998, err=0; a second start pulsed in cycle 2 is ignored.
- a=0x12A4, b=0x0001 -> err=1, sum=0x012F5 (digit1 carry forced 0), hex1=1111111 blank.
- a=0x5555, b=0x4445, rst pulsed in cycle 3 -> busy=0, sum=0 immediately, no done pulse; a later start completes normally with sum=0x10000.
- BCD_SUB_EN defined, sub=1, a=0x0100, b=0x0250 -> neg=1, sum=0x00150, done in cycle 9; then sub=1, a=0x0250, b=0x0100 -> neg=0, sum=0x00150, done in cycle 5.

Source files
------------

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bus for bcd_serial_adder; the sub select exists only when BCD_SUB_EN is defined.
interface bcd_serial_adder_if #(
    parameter int unsigned DIGITS = 4
);
    logic                      start;
    logic [4*DIGITS-1:0]       a;
    logic [4*DIGITS-1:0]       b;
`ifdef BCD_SUB_EN
    logic                      sub;
`endif
    logic                      busy;
    logic                      done;
    logic                      err;
    logic                      neg;
    logic [4*(DIGITS+1)-1:0]   sum;
    logic [7*(DIGITS+1)-1:0]   hex;

    modport master (
        output start, a, b,
`ifdef BCD_SUB_EN
        output sub,
`endif
        input  busy, done, err, neg, sum, hex
    );

    modport slave (
        input  start, a, b,
`ifdef BCD_SUB_EN
        input  sub,
`endif
        output busy, done, err, neg, sum, hex
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder (LSD first) with per-digit seven-segment decode.
// Optional BCD_SUB_EN adds nine's-complement subtraction with a COMP magnitude pass.
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    bcd_serial_adder_if.slave   bus
);
    localparam int unsigned OP_W  = 4 * DIGITS;
    localparam int unsigned SUM_W = 4 * (DIGITS + 1);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
`ifdef BCD_SUB_EN
        , S_COMP = 2'd3
`endif
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [OP_W-1:0]    r_a, w_a_nxt;
    logic [OP_W-1:0]    r_b, w_b_nxt;
    logic [SUM_W-1:0]   r_sum, w_sum_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_carry, w_carry_nxt;
    logic               r_err, w_err_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
`ifdef BCD_SUB_EN
    logic               r_sub, w_sub_nxt;
    logic               r_neg, w_neg_nxt;
`endif

    logic [3:0]         w_x, w_y_raw, w_y, w_dig;
    logic [4:0]         w_t;
    logic               w_bad, w_cout, w_last;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Next-state, digit datapath and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_sum_nxt   = r_sum;
        w_idx_nxt   = r_idx;
        w_carry_nxt = r_carry;
        w_err_nxt   = r_err;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
`ifdef BCD_SUB_EN
        w_sub_nxt   = r_sub;
        w_neg_nxt   = r_neg;
`endif
        w_x     = r_a[r_idx*4 +: 4];
        w_y_raw = r_b[r_idx*4 +: 4];
        w_bad   = (w_x > 4'd9) || (w_y_raw > 4'd9);
        w_y     = w_y_raw;
`ifdef BCD_SUB_EN
        if (r_sub) w_y = 4'd9 - w_y_raw;
        // COMP re-complements the stored difference to obtain its magnitude
        if (r_state == S_COMP) begin
            w_x   = 4'd0;
            w_y   = 4'd9 - r_sum[r_idx*4 +: 4];
            w_bad = r_sum[r_idx*4 +: 4] > 4'd9;
        end
`endif
        w_t = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, r_carry};
        if (w_bad) begin
            w_dig  = 4'hF;
            w_cout = 1'b0;
        end else if (w_t > 5'd9) begin
            w_dig  = 4'(w_t - 5'd10);
            w_cout = 1'b1;
        end else begin
            w_dig  = w_t[3:0];
            w_cout = 1'b0;
        end
        w_last = (r_idx == IDX_W'(DIGITS - 1));

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_a_nxt     = bus.a;
                    w_b_nxt     = bus.b;
                    w_idx_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
`ifdef BCD_SUB_EN
                    w_sub_nxt   = bus.sub;
                    w_neg_nxt   = 1'b0;
                    w_carry_nxt = bus.sub;
`else
                    w_carry_nxt = 1'b0;
`endif
                end
            end
            S_RUN: begin
                w_sum_nxt[r_idx*4 +: 4] = w_dig;
                w_err_nxt   = r_err | w_bad;
                w_carry_nxt = w_cout;
                w_idx_nxt   = r_idx + IDX_W'(1);
                if (w_last) begin
                    w_sum_nxt[4*DIGITS +: 4] = {3'b000, w_cout};
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
`ifdef BCD_SUB_EN
                    if (r_sub) begin
                        w_sum_nxt[4*DIGITS +: 4] = 4'd0;
                        if (!w_cout) begin
                            w_neg_nxt   = 1'b1;
                            w_carry_nxt = 1'b1;
                            w_idx_nxt   = '0;
                            w_state_nxt = S_COMP;
                            w_busy_nxt  = 1'b1;
                            w_done_nxt  = 1'b0;
                        end
                    end
`endif
                end
            end
`ifdef BCD_SUB_EN
            S_COMP: begin
                w_sum_nxt[r_idx*4 +: 4] = w_dig;
                w_carry_nxt = w_cout;
                w_idx_nxt   = r_idx + IDX_W'(1);
                if (w_last) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef BCD_SUB_EN
            r_sub   <= 1'b0;
            r_neg   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_sum   <= w_sum_nxt;
            r_idx   <= w_idx_nxt;
            r_carry <= w_carry_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef BCD_SUB_EN
            r_sub   <= w_sub_nxt;
            r_neg   <= w_neg_nxt;
`endif
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.sum  = r_sum;
`ifdef BCD_SUB_EN
    assign bus.neg  = r_neg;
`else
    assign bus.neg  = 1'b0;
`endif

    for (genvar g = 0; g <= DIGITS; g++) begin : g_hex
        assign bus.hex[7*g +: 7] = seg7(r_sum[4*g +: 4]);
    end
endmodule
